// File: rtl/amdc_adc_axi_regbank.sv
// amdc_adc_axi_regbank
//   AXI4-Lite slave register bank for the AMDC ADC peripheral.
//   Word map (byte address >> 2):
//     0 .. NUM_CFG-1             : CFG[k], read/write, byte strobes honoured
//     NUM_CFG                    : STATUS, bit0 new_data (W1C), bit1 overrun (W1C),
//                                  bits[17:16] irq_mask (RW)
//     NUM_CFG+1 .. NUM_CFG+NUM_CH: SAMPLE[k], read-only
//     anything else              : SLVERR, read data 0, writes dropped
//
// Ports
//   s00_axi_aclk / s00_axi_aresetn : clock, synchronous active-low reset
//   s00_axi_aw* / w* / b*          : AXI4-Lite write address, data, response
//   s00_axi_ar* / r*               : AXI4-Lite read address, data
//   sample_valid / sample_data     : one-cycle capture strobe and packed channel samples
//   cfg_out                        : packed CFG register contents, CFG[k] at [k*32 +: 32]
//   irq                            : registered, high while (status & irq_mask) != 0
module amdc_adc_axi_regbank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_CFG            = 4,
    parameter int NUM_CH             = 8,
    parameter int SAMPLE_WIDTH       = 16,
    parameter int SIGN_EXTEND        = 1
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    input  logic                              sample_valid,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0]    sample_data,
    output logic [NUM_CFG*32-1:0]             cfg_out,
    output logic                              irq
);

    localparam int         IDX_W      = C_S_AXI_ADDR_WIDTH - 2;
    localparam int         STATUS_IDX = NUM_CFG;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_SLV   = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_DATA } rstate_t;

    wstate_t     r_wstate, w_wstate_nxt;
    rstate_t     r_rstate, w_rstate_nxt;

    logic [31:0] r_cfg    [NUM_CFG];
    logic [31:0] r_sample [NUM_CH];
    logic        r_new_data;
    logic        r_overrun;
    logic [1:0]  r_irq_mask;
    logic        r_irq;
    logic [1:0]  r_bresp;
    logic [1:0]  r_rresp;
    logic [31:0] r_rdata;

    logic             w_wr_fire;
    logic             w_rd_fire;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_wr_is_cfg;
    logic             w_wr_is_status;
    logic [1:0]       w_wr_resp;
    logic [1:0]       w_w1c;
    logic [31:0]      w_rd_data;
    logic [1:0]       w_rd_resp;

    // Protection bits and byte offsets carry no information for word registers.
    logic w_unused;
    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    function automatic logic [31:0] ext_sample(input logic [SAMPLE_WIDTH-1:0] s);
        if (SIGN_EXTEND != 0)
            return 32'($signed(s));
        else
            return 32'(s);
    endfunction

    assign w_wr_idx = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_rd_idx = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

    // ---------------- write channel FSM ----------------
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn)
            r_wstate <= W_IDLE;
        else
            r_wstate <= w_wstate_nxt;
    end

    // Address and data are only ever accepted together; ready is gated by reset
    // so no handshake can be advertised while the bank is held in reset.
    always_comb begin
        w_wstate_nxt   = r_wstate;
        w_wr_fire      = 1'b0;
        s00_axi_bvalid = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (s00_axi_aresetn && s00_axi_awvalid && s00_axi_wvalid) begin
                    w_wr_fire    = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                s00_axi_bvalid = 1'b1;
                if (s00_axi_bready)
                    w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    assign s00_axi_awready = w_wr_fire;
    assign s00_axi_wready  = w_wr_fire;
    assign s00_axi_bresp   = r_bresp;

    // ---------------- read channel FSM ----------------
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn)
            r_rstate <= R_IDLE;
        else
            r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt   = r_rstate;
        w_rd_fire      = 1'b0;
        s00_axi_rvalid = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (s00_axi_aresetn && s00_axi_arvalid) begin
                    w_rd_fire    = 1'b1;
                    w_rstate_nxt = R_DATA;
                end
            end
            R_DATA: begin
                s00_axi_rvalid = 1'b1;
                if (s00_axi_rready)
                    w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    assign s00_axi_arready = w_rd_fire;
    assign s00_axi_rdata   = r_rdata;
    assign s00_axi_rresp   = r_rresp;

    // ---------------- address decode ----------------
    always_comb begin
        w_wr_is_cfg = 1'b0;
        for (int k = 0; k < NUM_CFG; k++)
            if (w_wr_idx == IDX_W'(k))
                w_wr_is_cfg = 1'b1;
        w_wr_is_status = (w_wr_idx == IDX_W'(STATUS_IDX));
        w_wr_resp      = (w_wr_is_cfg || w_wr_is_status) ? RESP_OKAY : RESP_SLV;
    end

    // Read mux works from current register values, so a read accepted on the
    // same edge as a write or a sample capture returns the pre-update contents.
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_SLV;
        for (int k = 0; k < NUM_CFG; k++) begin
            if (w_rd_idx == IDX_W'(k)) begin
                w_rd_data = r_cfg[k];
                w_rd_resp = RESP_OKAY;
            end
        end
        if (w_rd_idx == IDX_W'(STATUS_IDX)) begin
            w_rd_data = {14'd0, r_irq_mask, 14'd0, r_overrun, r_new_data};
            w_rd_resp = RESP_OKAY;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_rd_idx == IDX_W'(NUM_CFG + 1 + k)) begin
                w_rd_data = r_sample[k];
                w_rd_resp = RESP_OKAY;
            end
        end
    end

    // ---------------- response registers ----------------
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_bresp <= RESP_OKAY;
            r_rresp <= RESP_OKAY;
            r_rdata <= '0;
        end else begin
            if (w_wr_fire)
                r_bresp <= w_wr_resp;
            if (w_rd_fire) begin
                r_rresp <= w_rd_resp;
                r_rdata <= w_rd_data;
            end
        end
    end

    // ---------------- configuration registers ----------------
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            for (int k = 0; k < NUM_CFG; k++)
                r_cfg[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CFG; k++)
                for (int b = 0; b < 4; b++)
                    if (w_wr_fire && (w_wr_idx == IDX_W'(k)) && s00_axi_wstrb[b])
                        r_cfg[k][b*8 +: 8] <= s00_axi_wdata[b*8 +: 8];
        end
    end

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
        assign cfg_out[g*32 +: 32] = r_cfg[g];
    end

    // ---------------- status, irq and sample capture ----------------
    // W1C only acts with the byte-0 strobe; a same-edge capture re-sets the bit.
    assign w_w1c = (w_wr_fire && w_wr_is_status && s00_axi_wstrb[0]) ?
                   s00_axi_wdata[1:0] : 2'b00;

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_new_data <= 1'b0;
            r_overrun  <= 1'b0;
            r_irq_mask <= 2'b00;
            r_irq      <= 1'b0;
            for (int k = 0; k < NUM_CH; k++)
                r_sample[k] <= '0;
        end else begin
            r_new_data <= sample_valid | (r_new_data & ~w_w1c[0]);
            r_overrun  <= (sample_valid & r_new_data) | (r_overrun & ~w_w1c[1]);
            if (w_wr_fire && w_wr_is_status && s00_axi_wstrb[2])
                r_irq_mask <= s00_axi_wdata[17:16];
            r_irq <= |({r_overrun, r_new_data} & r_irq_mask);
            if (sample_valid)
                for (int k = 0; k < NUM_CH; k++)
                    r_sample[k] <= ext_sample(sample_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
        end
    end

    assign irq = r_irq;

endmodule

// File: tb/tb_amdc_adc_axi_regbank.sv
// tb_amdc_adc_axi_regbank
//   Bench for amdc_adc_axi_regbank with default parameters
//   (NUM_CFG=4, NUM_CH=8, SAMPLE_WIDTH=16, SIGN_EXTEND=1).
//   Table of AXI read/write vectors with expected data/response, plus hand
//   sequences for sample capture, irq timing, back-pressure and reset abort.
module tb_amdc_adc_axi_regbank;

    logic         clk;
    logic         aresetn;
    logic [5:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [5:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic         sample_valid;
    logic [127:0] sample_data;
    logic [127:0] cfg_out;
    logic         irq;

    amdc_adc_axi_regbank dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .sample_valid    (sample_valid),
        .sample_data     (sample_data),
        .cfg_out         (cfg_out),
        .irq             (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] SLV = 2'b10;

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t        vecs[$];
    logic [33:0] rq[$];
    logic [1:0]  bq[$];
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    endtask

    task automatic tmo(input string nm);
        n_total++;
        $display("FAIL %s: handshake not seen within cycle budget", nm);
    endtask

    task automatic addv(input logic wr, input logic [5:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] ed, input logic [1:0] er);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d; v.strb = s; v.exp_data = ed; v.exp_resp = er;
        vecs.push_back(v);
    endtask

    task automatic axi_write(input string nm, input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] er);
        logic [1:0] e;
        bit got;
        bq.push_back(er);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            got = awready && wready;
        end
        if (!got) tmo({nm, " accept"});
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        e = bq.pop_front();
        chk({nm, " bvalid"}, bvalid, 1'b1);
        chk({nm, " bresp"}, bresp, e);
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input string nm, input logic [5:0] a,
                            input logic [31:0] ed, input logic [1:0] er);
        logic [33:0] e;
        bit got;
        rq.push_back({er, ed});
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            got = arready;
        end
        if (!got) tmo({nm, " arready"});
        @(posedge clk); #1;
        arvalid = 1'b0;
        e = rq.pop_front();
        chk({nm, " rvalid"}, rvalid, 1'b1);
        chk({nm, " rdata"}, rdata, e[31:0]);
        chk({nm, " rresp"}, rresp, e[33:32]);
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic pulse(input logic [127:0] d);
        sample_data  = d;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    initial begin
        logic [33:0] e;
        aresetn = 1'b0; awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
        wvalid = 1'b0; bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        sample_valid = 1'b0; sample_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst awready", awready, 1'b0);
        chk("rst wready", wready, 1'b0);
        chk("rst bvalid", bvalid, 1'b0);
        chk("rst arready", arready, 1'b0);
        chk("rst rvalid", rvalid, 1'b0);
        chk("rst rdata", rdata, 32'h0);
        chk("rst bresp", bresp, 2'b00);
        chk("rst rresp", rresp, 2'b00);
        chk("rst cfg_out", cfg_out, 128'h0);
        chk("rst irq", irq, 1'b0);
        aresetn = 1'b1;
        @(posedge clk); #1;

        // Register map after reset, then CFG writes and read-back
        for (int i = 0; i < 13; i++)
            addv(1'b0, 6'(i * 4), 32'h0, 4'h0, 32'h0, OK);
        addv(1'b0, 6'h34, 32'h0, 4'h0, 32'h0, SLV);
        addv(1'b0, 6'h3C, 32'h0, 4'h0, 32'h0, SLV);
        addv(1'b1, 6'h00, 32'h1, 4'hF, 32'h0, OK);
        addv(1'b1, 6'h04, 32'h2, 4'hF, 32'h0, OK);
        addv(1'b1, 6'h08, 32'h3, 4'hF, 32'h0, OK);
        addv(1'b1, 6'h0C, 32'h4, 4'hF, 32'h0, OK);
        addv(1'b0, 6'h00, 32'h0, 4'h0, 32'h1, OK);
        addv(1'b0, 6'h04, 32'h0, 4'h0, 32'h2, OK);
        addv(1'b0, 6'h08, 32'h0, 4'h0, 32'h3, OK);
        addv(1'b0, 6'h0C, 32'h0, 4'h0, 32'h4, OK);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr)
                axi_write($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].exp_resp);
            else
                axi_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
        end
        chk("cfg_out after writes", cfg_out, 128'h00000004_00000003_00000002_00000001);

        vecs.delete();
        addv(1'b1, 6'h00, 32'hAABBCCDD, 4'b0101, 32'h0, OK);
        addv(1'b0, 6'h00, 32'h0, 4'h0, 32'h00BB00DD, OK);
        addv(1'b1, 6'h14, 32'hDEADBEEF, 4'hF, 32'h0, SLV);
        addv(1'b0, 6'h14, 32'h0, 4'h0, 32'h0, OK);
        addv(1'b1, 6'h34, 32'h12345678, 4'hF, 32'h0, SLV);
        addv(1'b1, 6'h10, 32'h00020000, 4'b0100, 32'h0, OK);
        addv(1'b0, 6'h10, 32'h0, 4'h0, 32'h00020000, OK);
        addv(1'b1, 6'h10, 32'h00000000, 4'b0100, 32'h0, OK);
        addv(1'b0, 6'h10, 32'h0, 4'h0, 32'h0, OK);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr)
                axi_write($sformatf("vecB%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].exp_resp);
            else
                axi_read($sformatf("vecB%0d", i), vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
        end
        chk("cfg_out partial strobe", cfg_out[31:0], 32'h00BB00DD);

        // Sample capture, extension, new_data / overrun, W1C
        pulse(128'h1234_0000_0000_0000_0000_0000_7FFF_8001);
        axi_read("sample0 signext", 6'h14, 32'hFFFF8001, OK);
        axi_read("sample1 positive", 6'h18, 32'h00007FFF, OK);
        axi_read("sample7", 6'h30, 32'h00001234, OK);
        axi_read("status new_data", 6'h10, 32'h1, OK);
        pulse(128'h0000_0000_0000_0000_0000_0000_0000_0005);
        axi_read("status overrun", 6'h10, 32'h3, OK);
        axi_read("sample0 second", 6'h14, 32'h5, OK);
        chk("irq masked off", irq, 1'b0);
        axi_write("w1c no byte0", 6'h10, 32'h00000003, 4'b1110, OK);
        axi_read("status kept", 6'h10, 32'h3, OK);
        axi_write("w1c clear", 6'h10, 32'h00000003, 4'b0001, OK);
        axi_read("status cleared", 6'h10, 32'h0, OK);

        // irq: enable new_data mask, strobe, rise two edges later, fall after W1C
        axi_write("set mask", 6'h10, 32'h00010000, 4'b0100, OK);
        axi_read("status mask", 6'h10, 32'h00010000, OK);
        sample_data  = 128'h6;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        chk("irq one edge after strobe", irq, 1'b0);
        @(posedge clk); #1;
        chk("irq two edges after strobe", irq, 1'b1);
        axi_write("irq w1c", 6'h10, 32'h1, 4'b0001, OK);
        chk("irq after w1c", irq, 1'b0);

        // Same-edge capture and W1C of new_data: set wins
        bq.push_back(OK);
        awaddr = 6'h10; wdata = 32'h1; wstrb = 4'b0001; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        sample_data = 128'h7; sample_valid = 1'b1;
        @(negedge clk);
        chk("same-edge awready", awready, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; sample_valid = 1'b0;
        chk("same-edge bvalid", bvalid, 1'b1);
        chk("same-edge bresp", bresp, bq.pop_front());
        @(posedge clk); #1;
        bready = 1'b0;
        axi_read("status set wins", 6'h10, 32'h00010001, OK);

        // Sample read on the capture edge returns the old sample
        rq.push_back({OK, 32'h7});
        araddr = 6'h14; arvalid = 1'b1; rready = 1'b1;
        sample_data = 128'h8; sample_valid = 1'b1;
        @(negedge clk);
        chk("same-edge arready", arready, 1'b1);
        @(posedge clk); #1;
        arvalid = 1'b0; sample_valid = 1'b0;
        e = rq.pop_front();
        chk("same-edge rvalid", rvalid, 1'b1);
        chk("same-edge old sample", rdata, e[31:0]);
        @(posedge clk); #1;
        rready = 1'b0;
        axi_read("sample0 new", 6'h14, 32'h8, OK);
        axi_read("status overrun2", 6'h10, 32'h00010003, OK);
        chk("irq masked status", irq, 1'b1);

        // Write response back-pressure with a second write queued behind it
        awaddr = 6'h04; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        chk("bp first accept", awready & wready, 1'b1);
        @(posedge clk); #1;
        awaddr = 6'h08; wdata = 32'h66;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp bvalid c%0d", i), bvalid, 1'b1);
            chk($sformatf("bp awready c%0d", i), awready, 1'b0);
            chk($sformatf("bp wready c%0d", i), wready, 1'b0);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        chk("bp second accept", awready & wready, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bp second bvalid", bvalid, 1'b1);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        axi_read("bp cfg1", 6'h04, 32'h55, OK);
        axi_read("bp cfg2", 6'h08, 32'h66, OK);

        // awvalid alone for three cycles is not accepted
        awaddr = 6'h0C; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("aw alone c%0d", i), awready | wready, 1'b0);
            @(posedge clk); #1;
        end
        wvalid = 1'b1;
        @(negedge clk);
        chk("aw+w accept", awready & wready, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("aw+w bvalid", bvalid, 1'b1);
        @(posedge clk); #1;
        bready = 1'b0;
        axi_read("aw+w cfg3", 6'h0C, 32'h77, OK);

        // Reset while a read response is pending
        araddr = 6'h00; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        chk("abort arready", arready, 1'b1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(posedge clk); #1;
        chk("abort rvalid held", rvalid, 1'b1);
        chk("abort rdata held", rdata, 32'h00BB00DD);
        aresetn = 1'b0;
        @(posedge clk); #1;
        chk("abort rvalid cleared", rvalid, 1'b0);
        chk("abort cfg_out cleared", cfg_out, 128'h0);
        chk("abort irq cleared", irq, 1'b0);
        aresetn = 1'b1;
        rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("no stale rvalid c%0d", i), rvalid, 1'b0);
        end
        rready = 1'b0;
        axi_read("post-reset cfg0", 6'h00, 32'h0, OK);
        axi_read("post-reset status", 6'h10, 32'h0, OK);
        axi_read("post-reset sample0", 6'h14, 32'h0, OK);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
